// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM measurement controller.
package pwm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WAIT_RISE,
    ST_MEAS_HIGH,
    ST_MEAS_LOW,
    ST_PUBLISH
  } pwm_state_t;

  // Extra accumulator bits: room for up to 128 summed periods.
  localparam int unsigned ACC_GROW = 7;

  // Period counter width; must hold 2^7 = 128.
  localparam int unsigned PER_W = 8;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchroniser plus one delay stage for single-cycle edge pulses.
module pwm_edge_sync (
  input  logic pwd_clk,
  input  logic sysreset,
  input  logic sig_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic dly;

  // Synchronise the asynchronous input and keep one older sample.
  always_ff @(posedge pwd_clk or negedge sysreset) begin
    if (!sysreset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= sig_async;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign level = sync2;
  assign rise  = sync2 & ~dly;
  assign fall  = ~sync2 & dly;

endmodule

// File: rtl/pwm_measure_ctrl.sv
// Round-robin PWM high/low period measurement over several sensor channels.
module pwm_measure_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                       pwd_clk,
  input  logic                       sysreset,
  input  logic [NUM_CH-1:0]          sensor_in,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          ch_mask,
  input  logic [2:0]                 avg_log2,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [$clog2(NUM_CH)-1:0]  result_ch,
  output logic [CNT_W-1:0]           result_high,
  output logic [CNT_W-1:0]           result_low,
  output logic                       result_timeout,
  output logic                       busy,
  output logic [$clog2(NUM_CH)-1:0]  cur_ch
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CHX_W = CH_W + 1;
  localparam int unsigned ACC_W = CNT_W + ACC_GROW;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  pwm_state_t state, state_nxt;

  logic [NUM_CH-1:0] s_level, s_rise, s_fall;
  logic [CH_W-1:0]   rr_ptr, sel_ch, ch_after;
  logic [CHX_W-1:0]  idx_w;
  logic              sel_found;
  logic [2:0]        avg_lat;
  logic [CNT_W-1:0]  high_cnt, low_cnt;
  logic [ACC_W-1:0]  acc_high, acc_low, sum_high, sum_low;
  logic [PER_W-1:0]  period_cnt, period_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic              lvl, rise, fall, to_hit, last_period;
  logic              pub_go, pub_to;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    pwm_edge_sync u_sync (
      .pwd_clk   (pwd_clk),
      .sysreset  (sysreset),
      .sig_async (sensor_in[g]),
      .level     (s_level[g]),
      .rise      (s_rise[g]),
      .fall      (s_fall[g])
    );
  end

  assign lvl         = s_level[cur_ch];
  assign rise        = s_rise[cur_ch];
  assign fall        = s_fall[cur_ch];
  assign to_hit      = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign period_nxt  = period_cnt + 1'b1;
  assign last_period = (period_nxt == (PER_W'(1) << avg_lat));
  assign sum_high    = acc_high + ACC_W'(high_cnt);
  assign sum_low     = acc_low + ACC_W'(low_cnt);
  assign ch_after    = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;

  // Pick the first eligible channel at or after the round-robin pointer.
  always_comb begin
    sel_ch    = '0;
    sel_found = 1'b0;
    idx_w     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx_w = {1'b0, rr_ptr} + CHX_W'(i);
      if (idx_w >= CHX_W'(NUM_CH)) idx_w = idx_w - CHX_W'(NUM_CH);
      if (!sel_found && ch_mask[idx_w[CH_W-1:0]]) begin
        sel_found = 1'b1;
        sel_ch    = idx_w[CH_W-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge pwd_clk or negedge sysreset) begin
    if (!sysreset) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next-state decode, status outputs and publish requests.
  always_comb begin
    state_nxt    = state;
    pub_go       = 1'b0;
    pub_to       = 1'b0;
    busy         = (state != ST_IDLE);
    result_valid = (state == ST_PUBLISH);
    case (state)
      ST_IDLE:   if (enable && (|ch_mask)) state_nxt = ST_SELECT;
      ST_SELECT: state_nxt = sel_found ? ST_WAIT_RISE : ST_IDLE;
      ST_WAIT_RISE: begin
        if (!enable)     state_nxt = ST_IDLE;
        else if (rise)   state_nxt = ST_MEAS_HIGH;
        else if (to_hit) begin state_nxt = ST_PUBLISH; pub_go = 1'b1; pub_to = 1'b1; end
      end
      ST_MEAS_HIGH: begin
        if (!enable)     state_nxt = ST_IDLE;
        else if (fall)   state_nxt = ST_MEAS_LOW;
        else if (to_hit) begin state_nxt = ST_PUBLISH; pub_go = 1'b1; pub_to = 1'b1; end
      end
      ST_MEAS_LOW: begin
        if (!enable) state_nxt = ST_IDLE;
        else if (rise) begin
          if (last_period) begin state_nxt = ST_PUBLISH; pub_go = 1'b1; end
          else             state_nxt = ST_MEAS_HIGH;
        end else if (to_hit) begin state_nxt = ST_PUBLISH; pub_go = 1'b1; pub_to = 1'b1; end
      end
      ST_PUBLISH: begin
        if (result_ready) state_nxt = (enable && (|ch_mask)) ? ST_SELECT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Measurement datapath; results are captured on the terminating edge or timeout.
  always_ff @(posedge pwd_clk or negedge sysreset) begin
    if (!sysreset) begin
      cur_ch         <= '0;
      rr_ptr         <= '0;
      avg_lat        <= '0;
      high_cnt       <= '0;
      low_cnt        <= '0;
      acc_high       <= '0;
      acc_low        <= '0;
      period_cnt     <= '0;
      to_cnt         <= '0;
      result_ch      <= '0;
      result_high    <= '0;
      result_low     <= '0;
      result_timeout <= 1'b0;
    end else begin
      case (state)
        ST_SELECT: begin
          cur_ch     <= sel_ch;
          avg_lat    <= avg_log2;
          acc_high   <= '0;
          acc_low    <= '0;
          period_cnt <= '0;
          high_cnt   <= '0;
          low_cnt    <= '0;
          to_cnt     <= '0;
        end
        ST_WAIT_RISE: if (enable) begin
          if (rise) begin
            high_cnt <= CNT_W'(1);
            to_cnt   <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_MEAS_HIGH: if (enable) begin
          if (fall) begin
            low_cnt <= CNT_W'(1);
            to_cnt  <= '0;
          end else begin
            if (lvl && (high_cnt != '1)) high_cnt <= high_cnt + 1'b1;
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_MEAS_LOW: if (enable) begin
          if (rise) begin
            acc_high   <= sum_high;
            acc_low    <= sum_low;
            period_cnt <= period_nxt;
            high_cnt   <= CNT_W'(1);
            to_cnt     <= '0;
          end else begin
            if (!lvl && (low_cnt != '1)) low_cnt <= low_cnt + 1'b1;
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase

      // Publish decision comes from the FSM decode so both processes agree on the edge.
      if (pub_go) begin
        result_ch      <= cur_ch;
        result_timeout <= pub_to;
        result_high    <= pub_to ? '0 : CNT_W'(sum_high >> avg_lat);
        result_low     <= pub_to ? '0 : CNT_W'(sum_low >> avg_lat);
        rr_ptr         <= ch_after;
      end
    end
  end

endmodule
